// File: rtl/pkt_tx_pkg.sv
// Shared types and defaults for the pkt_tx deficit-round-robin scheduler.
package pkt_tx_pkg;

  localparam int unsigned CHAN_NUMS_DEF   = 8;
  localparam int unsigned LEN_W_DEF       = 10;
  localparam int unsigned QW_DEF          = 11;
  localparam int unsigned DEF_W_DEF       = 12;
  localparam int unsigned WDOG_CYCLES_DEF = 4096;

  // A zero head length still occupies the link, so it is charged as one word.
  localparam int unsigned MIN_PKT_LEN = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SCAN  = 3'b010,
    ST_GRANT = 3'b100
  } sched_state_e;

endpackage

// File: rtl/pkt_tx_drr_sched_if.sv
// Request/grant bundle between the channel queues, the scheduler and the TX datapath.
interface pkt_tx_drr_sched_if
  import pkt_tx_pkg::*;
#(
  parameter int unsigned CHAN_NUMS = CHAN_NUMS_DEF,
  parameter int unsigned LEN_W     = LEN_W_DEF,
  parameter int unsigned QW        = QW_DEF
);
  localparam int unsigned IDX_W = $clog2(CHAN_NUMS);

  logic [CHAN_NUMS-1:0]       pkt_rdy;
  logic [CHAN_NUMS*LEN_W-1:0] head_len;
  logic [CHAN_NUMS*QW-1:0]    quantum;
  logic                       pkt_done;
  logic [CHAN_NUMS-1:0]       grant;
  logic [IDX_W-1:0]           grant_chan;
  logic                       busy;
  logic                       wdog_err;

  modport master (
    input  pkt_rdy, head_len, quantum, pkt_done,
    output grant, grant_chan, busy, wdog_err
  );

  modport slave (
    output pkt_rdy, head_len, quantum, pkt_done,
    input  grant, grant_chan, busy, wdog_err
  );

endinterface

// File: rtl/pkt_tx_drr_dcnt.sv
// Per-channel deficit register: clear, saturating credit add, and packet charge.
module pkt_tx_drr_dcnt
  import pkt_tx_pkg::*;
#(
  parameter int unsigned DEF_W = DEF_W_DEF,
  parameter int unsigned QW    = QW_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add_en,
  input  logic [QW-1:0]    add_val,
  input  logic             sub_en,
  input  logic [LEN_W-1:0] sub_val,
  output logic [DEF_W-1:0] cnt
);
  localparam int unsigned SUM_W = DEF_W + 1;

  logic [SUM_W-1:0] sum;

  always_comb sum = {1'b0, cnt} + SUM_W'(add_val);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: deficits are architectural state read by the scan, so each one is reset, not left at X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (add_en) begin
      cnt <= sum[DEF_W] ? '1 : sum[DEF_W-1:0];
    end else if (sub_en) begin
      cnt <= cnt - DEF_W'(sub_val);
    end
  end

endmodule

// File: rtl/pkt_tx_drr_sched.sv
// Deficit-round-robin grant scheduler for the SERDES TX path.
// Optional grant watchdog enabled by defining PKT_TX_SCHED_WDOG_EN.
module pkt_tx_drr_sched
  import pkt_tx_pkg::*;
#(
  parameter int unsigned CHAN_NUMS   = CHAN_NUMS_DEF,
  parameter int unsigned LEN_W       = LEN_W_DEF,
  parameter int unsigned QW          = QW_DEF,
  parameter int unsigned DEF_W       = DEF_W_DEF,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input logic                clk,
  input logic                rst_n,
  pkt_tx_drr_sched_if.master bus
);
  localparam int unsigned IDX_W = $clog2(CHAN_NUMS);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, ptr_inc;
  logic                 credited_q, credited_d;
  logic [CHAN_NUMS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     chan_q, chan_d;
  logic                 busy_q, busy_d;
  logic                 wdog_err_q, wdog_err_d;
  logic                 wdog_hit;

  logic [CHAN_NUMS-1:0] clr_vec, add_vec, sub_vec;
  logic [DEF_W-1:0]     deficit [CHAN_NUMS];
  logic [LEN_W-1:0]     raw_len, cur_len;
  logic [QW-1:0]        cur_quantum;

  always_comb begin
    raw_len     = bus.head_len[ptr_q*LEN_W +: LEN_W];
    cur_len     = (raw_len == '0) ? LEN_W'(MIN_PKT_LEN) : raw_len;
    cur_quantum = bus.quantum[ptr_q*QW +: QW];
    ptr_inc     = (ptr_q == IDX_W'(CHAN_NUMS - 1)) ? '0 : ptr_q + 1'b1;
  end

  for (genvar i = 0; i < CHAN_NUMS; i++) begin : g_dcnt
    pkt_tx_drr_dcnt #(.DEF_W(DEF_W), .QW(QW), .LEN_W(LEN_W)) u_dcnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr_vec[i]),
      .add_en  (add_vec[i]),
      .add_val (bus.quantum[i*QW +: QW]),
      .sub_en  (sub_vec[i]),
      .sub_val (cur_len),
      .cnt     (deficit[i])
    );
  end

`ifdef PKT_TX_SCHED_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);
  logic [WDOG_W-1:0] wdog_cnt;

  // Held at zero outside ST_GRANT, so it starts from zero on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wdog_cnt <= '0;
    else if (state_q != ST_GRANT) wdog_cnt <= '0;
    else                         wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic unused_wdog_cycles;
  assign unused_wdog_cycles = |WDOG_CYCLES;
  assign wdog_hit = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    credited_d = credited_q;
    grant_d    = grant_q;
    chan_d     = chan_q;
    busy_d     = busy_q;
    wdog_err_d = 1'b0;
    clr_vec    = '0;
    add_vec    = '0;
    sub_vec    = '0;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (|bus.pkt_rdy) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!bus.pkt_rdy[ptr_q] || cur_quantum == '0) begin
          clr_vec[ptr_q] = 1'b1;
          ptr_d          = ptr_inc;
          credited_d     = 1'b0;
          if (bus.pkt_rdy == '0) state_d = ST_IDLE;
        end else if (!credited_q) begin
          add_vec[ptr_q] = 1'b1;
          credited_d     = 1'b1;
        end else if (deficit[ptr_q] >= DEF_W'(cur_len)) begin
          sub_vec[ptr_q] = 1'b1;
          grant_d        = {{(CHAN_NUMS-1){1'b0}}, 1'b1} << ptr_q;
          chan_d         = ptr_q;
          busy_d         = 1'b1;
          state_d        = ST_GRANT;
        end else begin
          ptr_d      = ptr_inc;
          credited_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (bus.pkt_done) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ST_SCAN;
        end else if (wdog_hit) begin
          grant_d    = '0;
          busy_d     = 1'b0;
          wdog_err_d = 1'b1;
          ptr_d      = ptr_inc;
          credited_d = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      credited_q <= 1'b0;
      grant_q    <= '0;
      chan_q     <= '0;
      busy_q     <= 1'b0;
      wdog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      credited_q <= credited_d;
      grant_q    <= grant_d;
      chan_q     <= chan_d;
      busy_q     <= busy_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_chan = chan_q;
  assign bus.busy       = busy_q;
  assign bus.wdog_err   = wdog_err_q;

endmodule
